dma_peripheral_requester: RTL and testbench
===========================================

// Module: dma_peripheral_requester
// PURPOSE
//  Device-side end of the 8237A-style DREQ/DACK handshake: one I/O peripheral channel.
//  - Buffers bytes produced locally in a FIFO and raises Dreq toward the DMA controller.
//  - On Dack, supplies one byte per controller read strobe (I/O-to-memory transfer).
//  - Honours the controller's Dreq/Dack sense-polarity bits, single/demand modes and EOP.
// PARAMETERS
//  DEPTH      8  FIFO depth in bytes; power of 2, >=2.
//  THRESHOLD  1  Minimum FIFO occupancy that starts a request; 1..DEPTH.
// PORTS
//  Clock      in   1  Clock; all state updates on posedge.
//  Reset      in   1  Reset, synchronous, active-high.
//  Enable     in   1  1 = channel may request; 0 = no new request from IDLE.
//  DemandMode in   1  0 = single (one byte per request), 1 = demand (hold while data).
//  SenseDreq  in   1  0 = Dreq active high, 1 = Dreq active low (command reg bit 6).
//  SenseDack  in   1  0 = Dack active low, 1 = Dack active high (command reg bit 7).
//  WrEn       in   1  Local push strobe.
//  WrData     in   8  Local push data.
//  Dack       in   1  Raw acknowledge from controller (polarity per SenseDack).
//  Ior_n      in   1  Controller I/O read strobe, active low, synchronous.
//  Eop_n      in   1  End of process / terminal count from controller, active low.
//  Dreq       out  1  Request to controller (polarity per SenseDreq).
//  DataOut    out  8  Byte presented to bus; DataOE qualifies it.
//  DataOE     out  1  1 while DackAct & ~Ior_n & FIFO non-empty.
//  Full       out  1  FIFO count == DEPTH.
//  Count      out  $clog2(DEPTH+1)  FIFO occupancy.
//  Overflow   out  1  Sticky: push while Full and no pop that cycle.
//  Underrun   out  1  Sticky: read strobe edge while FIFO empty.
//  TcSeen     out  1  Sticky: Eop_n sampled low while DackAct.
// BEHAVIOUR
//  - DackAct = SenseDack ? Dack : ~Dack.  Dreq = DreqInt ^ SenseDreq (combinational).
//  - Reset: state IDLE, FIFO empty, Count=0, DreqInt=0 (Dreq = SenseDreq),
//    DataOE=0, DataOut=0, Overflow/Underrun/TcSeen=0. Sticky flags clear only by Reset.
//  - Pop event = DackAct & Ior_n_q & ~Ior_n (falling edge; Ior_n_q is registered,
//    reset to 1). One byte per strobe, never more.
//  - FIFO: push when WrEn & (~Full | pop). Push+pop same cycle: Count unchanged.
//    Pointers wrap modulo DEPTH. DataOut = head byte (combinational), 0 when empty.
//  - FSM states: IDLE, REQUEST, ACTIVE, RELEASE.
//  - IDLE: DreqInt=0. Enable & Count>=THRESHOLD -> REQUEST next cycle.
//  - REQUEST: DreqInt=1. DackAct -> ACTIVE. Enable dropped before DackAct -> IDLE.
//  - ACTIVE: DreqInt=1 in demand mode; single mode deasserts DreqInt in the same cycle
//    as the pop event (combinational on pop).
//      * ~Eop_n & DackAct -> RELEASE; set TcSeen (a pop in the same cycle completes).
//      * single mode, pop event -> RELEASE.
//      * demand mode, pop leaves Count==0 (no same-cycle push) -> RELEASE.
//      * ~DackAct before exit (controller pre-empted) -> IDLE; re-request from IDLE.
//  - RELEASE: DreqInt=0 for >=1 cycle; leave to IDLE when ~DackAct.
//  - Pop event outside ACTIVE is ignored (no pop), except Underrun still sets if empty.
//  - Latency: push to Dreq active = 2 cycles (state reg + FSM) when THRESHOLD met.
//  - Reset mid-transfer: all state to reset values next edge; FIFO contents discarded.
//  - Mode/sense inputs sampled every cycle; changing them mid-service is illegal.
// TESTING
//  1 Reset, SenseDreq=0,SenseDack=0: push 0xA5 -> Dreq=1 at +2 cycles; Dack=0, one
//    Ior_n pulse -> DataOut=0xA5, DataOE=1; single mode -> Dreq=0, Count=0, IDLE.
//  2 SenseDreq=1,SenseDack=1, demand mode, push 3 bytes 01,02,03: Dreq=0 (active);
//    Dack=1, 3 strobes -> bytes 01,02,03 in order, Dreq=1 after third, RELEASE->IDLE.
//  3 THRESHOLD=4: push 3 bytes -> Dreq stays inactive; 4th push -> Dreq active.
//  4 Demand mode, 5 bytes queued, Eop_n low on 2nd strobe -> 2 bytes out, TcSeen=1,
//    Dreq inactive, Count=3, re-request after Dack drops.
//  5 DEPTH=8: push 9 bytes with no service -> Full=1, Count=8, Overflow=1; push+pop
//    same cycle while full -> Count stays 8, Overflow unchanged.
//  6 Dack removed in ACTIVE with 2 bytes left -> IDLE, then REQUEST again; Reset
//    mid-transfer -> Dreq inactive, Count=0, flags 0 next cycle.

Source files
------------

// File: rtl/dma_peripheral_requester_if.sv
// DREQ/DACK bus between one I/O peripheral channel and an 8237A-style DMA controller.
interface dma_peripheral_requester_if;
    logic       Dreq;
    logic       Dack;
    logic       Ior_n;
    logic       Eop_n;
    logic [7:0] DataOut;
    logic       DataOE;

    modport master (input Dreq, DataOut, DataOE, output Dack, Ior_n, Eop_n);
    modport slave  (output Dreq, DataOut, DataOE, input Dack, Ior_n, Eop_n);
endinterface

// File: rtl/dma_peripheral_requester.sv
// Device-side DREQ/DACK requester: byte FIFO feeding an 8237A-style controller on I/O reads.
module dma_peripheral_requester #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned THRESHOLD = 1
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       Enable,
    input  logic                       DemandMode,
    input  logic                       SenseDreq,
    input  logic                       SenseDack,
    input  logic                       WrEn,
    input  logic [7:0]                 WrData,
    dma_peripheral_requester_if.slave  bus,
    output logic                       Full,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       Overflow,
    output logic                       Underrun,
    output logic                       TcSeen
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, REQUEST, ACTIVE, RELEASE} state_t;

    state_t        state, state_nxt;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          ior_q;
    logic          dack_act, strobe, empty, pop, push, dreq_int;

    assign dack_act = SenseDack ? bus.Dack : ~bus.Dack;
    assign strobe   = dack_act & ior_q & ~bus.Ior_n;
    assign empty    = (count == '0);
    assign Full     = (count == CW'(DEPTH));
    // Strobes outside ACTIVE never consume data.
    assign pop      = strobe & (state == ACTIVE) & ~empty;
    assign push     = WrEn & (~Full | pop);
    assign Count    = count;

    assign bus.Dreq    = dreq_int ^ SenseDreq;
    assign bus.DataOut = empty ? 8'h00 : mem[rd_ptr];
    assign bus.DataOE  = dack_act & ~bus.Ior_n & ~empty;

    // Next-state and request logic.
    always_comb begin
        state_nxt = state;
        dreq_int  = 1'b0;
        case (state)
            IDLE: begin
                if (Enable && (count >= CW'(THRESHOLD))) state_nxt = REQUEST;
            end
            REQUEST: begin
                dreq_int = 1'b1;
                if (dack_act)     state_nxt = ACTIVE;
                else if (!Enable) state_nxt = IDLE;
            end
            ACTIVE: begin
                // Single mode drops the request in the very cycle of its one strobe.
                dreq_int = DemandMode | ~strobe;
                if (!dack_act)                    state_nxt = IDLE;
                else if (!bus.Eop_n)              state_nxt = RELEASE;
                else if (!DemandMode && strobe)   state_nxt = RELEASE;
                else if (DemandMode && pop && (count == CW'(1)) && !push)
                                                  state_nxt = RELEASE;
            end
            RELEASE: begin
                if (!dack_act) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, pointers, occupancy and sticky flags.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            ior_q    <= 1'b1;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            Overflow <= 1'b0;
            Underrun <= 1'b0;
            TcSeen   <= 1'b0;
        end else begin
            state <= state_nxt;
            ior_q <= bus.Ior_n;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            Overflow <= Overflow | (WrEn & Full & ~pop);
            Underrun <= Underrun | (strobe & empty);
            TcSeen   <= TcSeen | (~bus.Eop_n & dack_act);
        end
    end

    // Data storage has no reset; the pointers define validity.
    always_ff @(posedge Clock) begin
        if (push) mem[wr_ptr] <= WrData;
    end

endmodule

// File: tb/tb_dma_peripheral_requester.sv
// Scoreboard bench: directed DREQ/DACK sequences, bytes checked by a negedge monitor.
module tb_dma_peripheral_requester;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable, demand, sense_dreq, sense_dack;
    logic       wr_en_a, wr_en_b;
    logic [7:0] wr_data_a, wr_data_b;
    logic       full_a, full_b, ovf_a, ovf_b, unr_a, unr_b, tc_a, tc_b;
    logic [3:0] count_a, count_b;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    logic       tb_ior_q = 1'b1;

    dma_peripheral_requester_if busa ();
    dma_peripheral_requester_if busb ();

    always #5 clk = ~clk;

    dma_peripheral_requester #(.DEPTH(8), .THRESHOLD(1)) dut_a (
        .Clock(clk), .Reset(rst), .Enable(enable), .DemandMode(demand),
        .SenseDreq(sense_dreq), .SenseDack(sense_dack),
        .WrEn(wr_en_a), .WrData(wr_data_a), .bus(busa.slave),
        .Full(full_a), .Count(count_a), .Overflow(ovf_a), .Underrun(unr_a), .TcSeen(tc_a)
    );

    dma_peripheral_requester #(.DEPTH(8), .THRESHOLD(4)) dut_b (
        .Clock(clk), .Reset(rst), .Enable(enable), .DemandMode(demand),
        .SenseDreq(sense_dreq), .SenseDack(sense_dack),
        .WrEn(wr_en_b), .WrData(wr_data_b), .bus(busb.slave),
        .Full(full_b), .Count(count_b), .Overflow(ovf_b), .Underrun(unr_b), .TcSeen(tc_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [7:0] d, input bit expect_out);
        wr_en_a   = 1'b1;
        wr_data_a = d;
        if (expect_out) exp_q.push_back(d);
        tick();
        wr_en_a = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] d);
        wr_en_b   = 1'b1;
        wr_data_b = d;
        tick();
        wr_en_b = 1'b0;
    endtask

    task automatic strobe_a();
        busa.Ior_n = 1'b0;
        tick();
        busa.Ior_n = 1'b1;
        tick();
    endtask

    // Bench-side view of the strobe edge the DUT will register at the next posedge.
    always @(posedge clk) tb_ior_q <= rst ? 1'b1 : busa.Ior_n;

    always @(negedge clk) begin
        if (!rst && busa.DataOE && tb_ior_q && !busa.Ior_n) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_byte: got %0h expected none", busa.DataOut);
            end else begin
                check("data_byte", 32'(busa.DataOut), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; enable = 1'b0; demand = 1'b0; sense_dreq = 1'b0; sense_dack = 1'b0;
        wr_en_a = 1'b0; wr_en_b = 1'b0; wr_data_a = 8'h00; wr_data_b = 8'h00;
        busa.Dack = 1'b1; busa.Ior_n = 1'b1; busa.Eop_n = 1'b1;
        busb.Dack = 1'b1; busb.Ior_n = 1'b1; busb.Eop_n = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_dreq", busa.Dreq, 0);
        check("rst_count", count_a, 0);
        check("rst_oe", busa.DataOE, 0);
        check("rst_dataout", busa.DataOut, 0);
        check("rst_full", full_a, 0);
        check("rst_flags", {ovf_a, unr_a, tc_a}, 0);
        check("rst_dreq_b", busb.Dreq, 0);

        // Single mode, active-high Dreq, active-low Dack.
        enable = 1'b1;
        push_a(8'hA5, 1'b1);
        check("t1_dreq_1cyc", busa.Dreq, 0);
        check("t1_count", count_a, 1);
        tick();
        check("t1_dreq_2cyc", busa.Dreq, 1);
        busa.Dack = 1'b0;
        tick();
        busa.Ior_n = 1'b0;
        #1;
        check("t1_dreq_drop", busa.Dreq, 0);
        check("t1_oe", busa.DataOE, 1);
        check("t1_dataout", busa.DataOut, 8'hA5);
        tick();
        busa.Ior_n = 1'b1;
        busa.Dack  = 1'b1;
        #1;
        check("t1_count_after", count_a, 0);
        check("t1_dreq_release", busa.Dreq, 0);
        tick();
        tick();
        check("t1_dreq_idle", busa.Dreq, 0);

        // Strobe with an empty FIFO.
        busa.Dack  = 1'b0;
        busa.Ior_n = 1'b0;
        tick();
        busa.Ior_n = 1'b1;
        busa.Dack  = 1'b1;
        check("underrun", unr_a, 1);
        check("underrun_dreq", busa.Dreq, 0);

        // Threshold of 4 on the second instance.
        push_b(8'h31); push_b(8'h32); push_b(8'h33);
        tick(); tick();
        check("t3_dreq_below", busb.Dreq, 0);
        check("t3_count", count_b, 3);
        push_b(8'h34);
        check("t3_dreq_1cyc", busb.Dreq, 0);
        tick();
        check("t3_dreq_met", busb.Dreq, 1);

        // Demand mode, inverted senses.
        demand = 1'b1; sense_dreq = 1'b1; sense_dack = 1'b1;
        busa.Dack = 1'b0; busb.Dack = 1'b0;
        #1;
        check("t2_dreq_idle", busa.Dreq, 1);
        push_a(8'h01, 1'b1); push_a(8'h02, 1'b1); push_a(8'h03, 1'b1);
        check("t2_dreq_req", busa.Dreq, 0);
        check("t2_count", count_a, 3);
        busa.Dack = 1'b1;
        tick();
        strobe_a(); strobe_a();
        check("t2_dreq_hold", busa.Dreq, 0);
        check("t2_count_mid", count_a, 1);
        strobe_a();
        check("t2_dreq_end", busa.Dreq, 1);
        check("t2_count_end", count_a, 0);
        busa.Dack = 1'b0;
        tick(); tick();
        check("t2_dreq_idle_end", busa.Dreq, 1);

        // Terminal count on the second strobe.
        push_a(8'h11, 1'b1); push_a(8'h12, 1'b1); push_a(8'h13, 1'b1);
        push_a(8'h14, 1'b0); push_a(8'h15, 1'b0);
        check("t4_dreq_req", busa.Dreq, 0);
        busa.Dack = 1'b1;
        tick();
        strobe_a();
        busa.Ior_n = 1'b0;
        busa.Eop_n = 1'b0;
        tick();
        busa.Ior_n = 1'b1;
        busa.Eop_n = 1'b1;
        check("t4_tc", tc_a, 1);
        check("t4_dreq_inactive", busa.Dreq, 1);
        check("t4_count", count_a, 3);
        tick();
        check("t4_dreq_release", busa.Dreq, 1);
        busa.Dack = 1'b0;
        tick(); tick();
        check("t4_rerequest", busa.Dreq, 0);

        // Controller pre-empts with two bytes left.
        busa.Dack = 1'b1;
        tick();
        strobe_a();
        check("t6_count", count_a, 2);
        check("t6_dreq_active", busa.Dreq, 0);
        busa.Dack = 1'b0;
        tick();
        check("t6_dreq_idle", busa.Dreq, 1);
        tick();
        check("t6_rerequest", busa.Dreq, 0);
        busa.Dack = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_dreq", busa.Dreq, 1);
        check("t6_rst_count", count_a, 0);
        check("t6_rst_flags", {ovf_a, unr_a, tc_a}, 0);

        // Fill to full and overflow, then push+pop while full.
        enable    = 1'b0;
        busa.Dack = 1'b0;
        for (int i = 0; i < 8; i++) push_a(8'(8'h20 + i), 1'b1);
        check("t5_full", full_a, 1);
        check("t5_no_ovf_yet", ovf_a, 0);
        push_a(8'h28, 1'b0);
        check("t5_count", count_a, 8);
        check("t5_ovf", ovf_a, 1);
        enable = 1'b1;
        tick();
        busa.Dack = 1'b1;
        tick();
        wr_en_a    = 1'b1;
        wr_data_a  = 8'h29;
        exp_q.push_back(8'h29);
        busa.Ior_n = 1'b0;
        tick();
        wr_en_a    = 1'b0;
        busa.Ior_n = 1'b1;
        check("t5_pushpop_count", count_a, 8);
        check("t5_pushpop_full", full_a, 1);
        check("t5_pushpop_ovf", ovf_a, 1);
        tick();
        for (int i = 0; i < 8; i++) strobe_a();
        check("t5_drain_count", count_a, 0);
        check("t5_drain_dreq", busa.Dreq, 1);
        busa.Dack = 1'b0;
        tick(); tick();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
